// File: rtl/hazard3_operand_fwd.sv
// ============================================================================
// Module   : hazard3_operand_fwd
// Brief    : Operand resolution between issue and execute. Drives register-file
//            reads, forwards ex/wb results, and holds issue on in-flight loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard3_operand_fwd #(
  parameter int N_REGS = 32,
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [W_ADDR-1:0] iss_rs1,
  input  logic [W_ADDR-1:0] iss_rs2,
  output logic [W_ADDR-1:0] rf_raddr1,
  output logic [W_ADDR-1:0] rf_raddr2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,
  input  logic              ex_wen,
  input  logic [W_ADDR-1:0] ex_rd,
  input  logic [W_DATA-1:0] ex_wdata,
  input  logic              wb_wen,
  input  logic [W_ADDR-1:0] wb_waddr,
  input  logic [W_DATA-1:0] wb_wdata,
  input  logic              wb_is_ld,
  input  logic              ld_issue,
  input  logic [W_ADDR-1:0] ld_rd,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [W_DATA-1:0] op1,
  output logic [W_DATA-1:0] op2
);

  localparam logic [W_ADDR-1:0] c_x0 = '0;

  logic              r_s_full;
  logic [W_ADDR-1:0] r_s_rs1;
  logic [W_ADDR-1:0] r_s_rs2;
  logic              r_cap1_v;
  logic              r_cap2_v;
  logic [W_DATA-1:0] r_cap1_d;
  logic [W_DATA-1:0] r_cap2_d;
  logic [N_REGS-1:0] r_busy;

  logic              w_accept;
  logic              w_consume;
  logic              w_ld_wb;
  logic              w_blocked1;
  logic              w_blocked2;
  logic [N_REGS-1:0] w_busy_nxt;

  function automatic logic [W_DATA-1:0] f_resolve(
    input logic [W_ADDR-1:0] rs,
    input logic              cap_v,
    input logic [W_DATA-1:0] cap_d,
    input logic [W_DATA-1:0] rdata,
    input logic              e_wen,
    input logic [W_ADDR-1:0] e_rd,
    input logic [W_DATA-1:0] e_data,
    input logic              w_wen,
    input logic [W_ADDR-1:0] w_addr,
    input logic [W_DATA-1:0] w_data
  );
    // Youngest value wins: ex, then wb, then the same-edge capture, then the file.
    if (rs == c_x0)                    return '0;
    else if (e_wen && (e_rd == rs))    return e_data;
    else if (w_wen && (w_addr == rs))  return w_data;
    else if (cap_v)                    return cap_d;
    else                               return rdata;
  endfunction

  assign w_ld_wb    = wb_wen && wb_is_ld;
  assign w_blocked1 = r_busy[r_s_rs1] && !(w_ld_wb && (wb_waddr == r_s_rs1));
  assign w_blocked2 = r_busy[r_s_rs2] && !(w_ld_wb && (wb_waddr == r_s_rs2));

  assign op_valid  = r_s_full && !w_blocked1 && !w_blocked2;
  assign w_consume = op_valid && op_ready;
  assign iss_ready = !r_s_full || w_consume;
  assign w_accept  = iss_valid && iss_ready;

  // A held entry keeps re-reading its own registers so late writes are seen.
  assign rf_raddr1 = w_accept ? iss_rs1 : r_s_rs1;
  assign rf_raddr2 = w_accept ? iss_rs2 : r_s_rs2;

  assign op1 = f_resolve(r_s_rs1, r_cap1_v, r_cap1_d, rf_rdata1,
                         ex_wen, ex_rd, ex_wdata, wb_wen, wb_waddr, wb_wdata);
  assign op2 = f_resolve(r_s_rs2, r_cap2_v, r_cap2_d, rf_rdata2,
                         ex_wen, ex_rd, ex_wdata, wb_wen, wb_waddr, wb_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_full <= 1'b0;
      r_s_rs1  <= '0;
      r_s_rs2  <= '0;
    end else if (w_accept) begin
      r_s_full <= 1'b1;
      r_s_rs1  <= iss_rs1;
      r_s_rs2  <= iss_rs2;
    end else if (w_consume) begin
      r_s_full <= 1'b0;
    end
  end

  // The file returns pre-write data for a read on its write edge; remember that write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap1_v <= 1'b0;
      r_cap2_v <= 1'b0;
      r_cap1_d <= '0;
      r_cap2_d <= '0;
    end else begin
      r_cap1_v <= wb_wen && (wb_waddr == rf_raddr1) && (rf_raddr1 != c_x0);
      r_cap2_v <= wb_wen && (wb_waddr == rf_raddr2) && (rf_raddr2 != c_x0);
      r_cap1_d <= wb_wdata;
      r_cap2_d <= wb_wdata;
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ld_wb)  w_busy_nxt[wb_waddr] = 1'b0;
    if (ld_issue) w_busy_nxt[ld_rd]    = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard3_operand_fwd.sv
// ============================================================================
// Module   : tb_hazard3_operand_fwd
// Brief    : Directed and random checks of hazard3_operand_fwd against a
//            newest-value / pending-load reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard3_operand_fwd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_is_ld, ld_issue;
  logic [4:0]  ld_rd;
  logic        op_valid, op_ready;
  logic [31:0] op1, op2;

  hazard3_operand_fwd #(.N_REGS(32), .W_DATA(32), .W_ADDR(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_wdata(ex_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_is_ld(wb_is_ld), .ld_issue(ld_issue), .ld_rd(ld_rd),
    .op_valid(op_valid), .op_ready(op_ready), .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  // Register file: one-cycle read latency, read returns pre-write data on a write edge.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
    if (wb_wen && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Reference model: architectural values, pending loads, and the held request.
  logic [31:0] arch [32];
  bit          pend [32];
  bit          m_full;
  logic [4:0]  m_rs1, m_rs2;
  bit          e_valid, e_ready;

  function automatic logic [31:0] newest(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (ex_wen && ex_rd == r) return ex_wdata;
    if (wb_wen && wb_waddr == r) return wb_wdata;
    return arch[r];
  endfunction

  function automatic bit waiting(input logic [4:0] r);
    return pend[r] && !(wb_wen && wb_is_ld && wb_waddr == r);
  endfunction

  task automatic model_reset();
    m_full = 0; m_rs1 = 0; m_rs2 = 0;
    for (int i = 0; i < 32; i++) pend[i] = 0;
  endtask

  task automatic model_check();
    e_valid = m_full && !waiting(m_rs1) && !waiting(m_rs2);
    e_ready = !m_full || (e_valid && op_ready);
    chk("op_valid", {31'd0, op_valid}, {31'd0, e_valid});
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, e_ready});
    chk("op1", op1, newest(m_rs1));
    chk("op2", op2, newest(m_rs2));
    chk("raddr1", {27'd0, rf_raddr1}, {27'd0, (iss_valid && e_ready) ? iss_rs1 : m_rs1});
    chk("raddr2", {27'd0, rf_raddr2}, {27'd0, (iss_valid && e_ready) ? iss_rs2 : m_rs2});
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (wb_wen && wb_waddr != 5'd0) arch[wb_waddr] = wb_wdata;
    if (wb_wen && wb_is_ld) pend[wb_waddr] = 0;
    if (ld_issue && ld_rd != 5'd0) pend[ld_rd] = 1;
    if (iss_valid && e_ready) begin
      m_full = 1; m_rs1 = iss_rs1; m_rs2 = iss_rs2;
    end else if (e_valid && op_ready) begin
      m_full = 0;
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0;
    ex_wen = 0; ex_rd = 0; ex_wdata = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0; wb_is_ld = 0;
    ld_issue = 0; ld_rd = 0; op_ready = 0;
  endtask

  task automatic settle();
    #4;
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'd0; arch[i] = 32'd0;
    end
    rf_rdata1 = 0; rf_rdata2 = 0;
    model_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    rst_n = 1;

    // Same-edge write covered by capture
    idle(); iss_valid = 1; iss_rs1 = 5; wb_wen = 1; wb_waddr = 5; wb_wdata = 32'hAAAA5555;
    settle(); chk("se_acc", {31'd0, iss_ready}, 32'd1); advance();
    idle(); op_ready = 1;
    settle(); chk("se_valid", {31'd0, op_valid}, 32'd1); chk("se_op1", op1, 32'hAAAA5555); advance();

    // ex beats wb
    idle(); iss_valid = 1; iss_rs2 = 7; settle(); advance();
    idle(); op_ready = 1; ex_wen = 1; ex_rd = 7; ex_wdata = 32'h11;
    wb_wen = 1; wb_waddr = 7; wb_wdata = 32'h22;
    settle(); chk("exwb_op2", op2, 32'h11); advance();

    // x0 never forwarded
    idle(); iss_valid = 1; ex_wen = 1; ex_rd = 0; ex_wdata = 32'hFFFF; settle(); advance();
    idle(); op_ready = 1; ex_wen = 1; ex_rd = 0; ex_wdata = 32'hFFFF;
    settle(); chk("x0_valid", {31'd0, op_valid}, 32'd1); chk("x0_op1", op1, 32'd0); advance();

    // Load scoreboard
    idle(); ld_issue = 1; ld_rd = 9; settle(); advance();
    idle(); iss_valid = 1; iss_rs1 = 9; settle(); chk("ld_acc", {31'd0, iss_ready}, 32'd1); advance();
    for (int k = 0; k < 3; k++) begin
      idle(); op_ready = 1;
      settle(); chk("ld_block", {31'd0, op_valid}, 32'd0); chk("ld_stall", {31'd0, iss_ready}, 32'd0);
      advance();
    end
    idle(); op_ready = 1; wb_wen = 1; wb_is_ld = 1; wb_waddr = 9; wb_wdata = 32'hDEAD;
    settle(); chk("ld_fwd_valid", {31'd0, op_valid}, 32'd1); chk("ld_fwd_op1", op1, 32'hDEAD); advance();
    idle(); iss_valid = 1; iss_rs1 = 9; settle(); advance();
    idle(); op_ready = 1;
    settle(); chk("ld_clear", {31'd0, op_valid}, 32'd1); chk("ld_clear_op1", op1, 32'hDEAD); advance();

    // Backpressure with a write landing during the hold
    idle(); iss_valid = 1; iss_rs1 = 3; settle(); advance();
    for (int k = 0; k < 3; k++) begin
      idle(); iss_valid = 1; iss_rs1 = 6;
      if (k == 0) begin wb_wen = 1; wb_waddr = 3; wb_wdata = 32'h44; end
      settle(); chk("bp_op1", op1, 32'h44); chk("bp_stall", {31'd0, iss_ready}, 32'd0);
      advance();
    end
    idle(); iss_valid = 1; iss_rs1 = 6; op_ready = 1;
    settle(); chk("bp_release", {31'd0, iss_ready}, 32'd1); chk("bp_rel_op1", op1, 32'h44); advance();
    idle(); op_ready = 1; settle(); advance();

    // Reset while holding a blocked entry
    idle(); ld_issue = 1; ld_rd = 4; iss_valid = 1; iss_rs1 = 4;
    wb_wen = 1; wb_waddr = 4; wb_wdata = 32'h1234;
    settle(); advance();
    idle();
    settle(); chk("pre_rst_valid", {31'd0, op_valid}, 32'd0); chk("pre_rst_op1", op1, 32'h1234);
    chk("pre_rst_ready", {31'd0, iss_ready}, 32'd0);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'd0, op_valid}, 32'd0); chk("mid_rst_op1", op1, 32'd0);
    chk("mid_rst_ready", {31'd0, iss_ready}, 32'd1);
    model_reset();
    advance();
    rst_n = 1;
    idle(); iss_valid = 1; iss_rs1 = 4; settle(); chk("post_rst_acc", {31'd0, iss_ready}, 32'd1); advance();
    idle(); op_ready = 1;
    settle(); chk("post_rst_busy", {31'd0, op_valid}, 32'd1); chk("post_rst_op1", op1, 32'h1234); advance();

    // Random traffic over a small register window to force frequent hazards
    for (int c = 0; c < 2000; c++) begin
      iss_valid = ($urandom_range(0, 9) < 7);
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      ex_wen    = ($urandom_range(0, 9) < 3);
      ex_rd     = 5'($urandom_range(0, 7));
      ex_wdata  = $urandom;
      wb_wen    = ($urandom_range(0, 1) == 1);
      wb_waddr  = 5'($urandom_range(0, 7));
      wb_wdata  = $urandom;
      wb_is_ld  = ($urandom_range(0, 1) == 1);
      ld_issue  = ($urandom_range(0, 99) < 15);
      ld_rd     = 5'($urandom_range(0, 7));
      op_ready  = ($urandom_range(0, 9) < 7);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
